// File: rtl/led_pkg.sv
// led_pkg: shared types and helpers for the LED timing stage and its button debouncers.
package led_pkg;
   typedef logic [1:0] speed_t;
   localparam int NUM_SPEEDS = 4;
   typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} db_state_t;
   function automatic int unsigned period_of(input int unsigned base_div, input speed_t spd);
      return base_div >> spd;
   endfunction
endpackage

// File: rtl/led_tick_gen_if.sv
// led_tick_gen_if: button input and tick/clock/speed outputs of the LED timing stage.
// With LED_TICK_PAUSE_EN defined the interface also carries the pause input.
interface led_tick_gen_if;
   import led_pkg::*;
   logic btn_speed;
   logic tick;
   logic clk_out;
   speed_t speed;
`ifdef LED_TICK_PAUSE_EN
   logic pause;
   modport master(input btn_speed, input pause, output tick, output clk_out, output speed);
   modport slave(output btn_speed, output pause, input tick, input clk_out, input speed);
`else
   modport master(input btn_speed, output tick, output clk_out, output speed);
   modport slave(output btn_speed, input tick, input clk_out, input speed);
`endif
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus debounce FSM; emits one press strobe per accepted press.
module btn_debounce
   import led_pkg::*;
#(
   parameter int DB_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic press
);
   localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [DW-1:0] LAST = DW'(DB_CYCLES - 1);
   logic [1:0] sync;
   logic btn_s;
   logic done;
   db_state_t state, state_nxt;
   logic [DW-1:0] dcnt, dcnt_nxt;
   assign btn_s = sync[1];
   assign done = dcnt == LAST;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sync  <= '0;
         state <= IDLE;
         dcnt  <= '0;
      end else begin
         sync  <= {sync[0], btn};
         state <= state_nxt;
         dcnt  <= dcnt_nxt;
      end
   // dcnt runs freely outside the wait states; every entry into a wait state clears it
   always_comb begin
      state_nxt = state;
      dcnt_nxt  = dcnt + DW'(1);
      press     = 1'b0;
      case (state)
         IDLE:
            if (btn_s) begin
               state_nxt = PRESS_WAIT;
               dcnt_nxt  = '0;
            end
         PRESS_WAIT:
            if (!btn_s) state_nxt = IDLE;
            else if (done) begin
               state_nxt = HELD;
               press     = 1'b1;
            end
         HELD:
            if (!btn_s) begin
               state_nxt = RELEASE_WAIT;
               dcnt_nxt  = '0;
            end
         RELEASE_WAIT:
            if (btn_s) state_nxt = HELD;
            else if (done) state_nxt = IDLE;
      endcase
   end
endmodule

// File: rtl/led_tick_gen.sv
// led_tick_gen: speed-selectable tick/clk_out divider feeding the LED pattern engine.
// Optional macro LED_TICK_PAUSE_EN adds a synchronized pause input that freezes the divider.
module led_tick_gen
   import led_pkg::*;
#(
   parameter int BASE_DIV  = 25000000,
   parameter int DB_CYCLES = 1000000
) (
   input logic clk_50M,
   input logic reset,
   led_tick_gen_if.master bus
);
   localparam int CW = $clog2(BASE_DIV);
   logic press;
   logic run;
   logic [CW-1:0] cnt;
   logic [CW-1:0] last;
   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_btn_debounce (
      .clk  (clk_50M),
      .rst_n(reset),
      .btn  (bus.btn_speed),
      .press(press)
   );
`ifdef LED_TICK_PAUSE_EN
   logic [1:0] pause_sync;
   always_ff @(posedge clk_50M or negedge reset)
      if (!reset) pause_sync <= '0;
      else pause_sync <= {pause_sync[0], bus.pause};
   assign run = ~pause_sync[1];
`else
   assign run = 1'b1;
`endif
   assign last = CW'(period_of(BASE_DIV, bus.speed) - 1);
   // a press outranks terminal count: the period restarts without a tick or clk_out toggle
   always_ff @(posedge clk_50M or negedge reset)
      if (!reset) begin
         cnt         <= '0;
         bus.speed   <= '0;
         bus.tick    <= 1'b0;
         bus.clk_out <= 1'b0;
      end else if (press) begin
         cnt       <= '0;
         bus.speed <= (bus.speed == speed_t'(NUM_SPEEDS - 1)) ? '0 : bus.speed + 2'd1;
         bus.tick  <= 1'b0;
      end else if (!run) begin
         bus.tick <= 1'b0;
      end else if (cnt == last) begin
         cnt         <= '0;
         bus.tick    <= 1'b1;
         bus.clk_out <= ~bus.clk_out;
      end else begin
         cnt      <= cnt + CW'(1);
         bus.tick <= 1'b0;
      end
endmodule

// File: tb/tb_led_tick_gen.sv
// tb_led_tick_gen: directed checks of led_tick_gen with BASE_DIV=16, DB_CYCLES=4.
module tb_led_tick_gen;
   import led_pkg::*;
   logic clk_50M = 1'b0;
   logic reset = 1'b0;
   int total = 0;
   int bad = 0;
   led_tick_gen_if bus();
   led_tick_gen #(.BASE_DIV(16), .DB_CYCLES(4)) dut (
      .clk_50M(clk_50M),
      .reset  (reset),
      .bus    (bus)
   );
   always #5 clk_50M = ~clk_50M;

   task automatic edges(input int n);
      repeat (n) begin
         @(posedge clk_50M);
         @(negedge clk_50M);
      end
   endtask

   task automatic cycles_to_tick(output int n);
      n = 0;
      do begin
         @(posedge clk_50M);
         @(negedge clk_50M);
         n++;
      end while (!bus.tick && n < 100);
   endtask

   task automatic press_once(input int hold);
      bus.btn_speed = 1'b1;
      edges(hold);
      bus.btn_speed = 1'b0;
      edges(10);
   endtask

   task automatic test_reset;
      int n;
      bus.btn_speed = 1'b0;
`ifdef LED_TICK_PAUSE_EN
      bus.pause = 1'b0;
`endif
      reset = 1'b0;
      edges(5);
      total += 3;
      if (bus.tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", bus.tick); end
      if (bus.clk_out !== 1'b0) begin bad++; $display("FAIL reset_clk_out got=%b want=0", bus.clk_out); end
      if (bus.speed !== 2'd0) begin bad++; $display("FAIL reset_speed got=%0d want=0", bus.speed); end
      reset = 1'b1;
      cycles_to_tick(n);
      total += 2;
      if (n != 16) begin bad++; $display("FAIL first_tick got=%0d want=16", n); end
      if (bus.clk_out !== 1'b1) begin bad++; $display("FAIL first_clk_out got=%b want=1", bus.clk_out); end
      cycles_to_tick(n);
      total += 2;
      if (n != 16) begin bad++; $display("FAIL second_tick got=%0d want=16", n); end
      if (bus.clk_out !== 1'b0) begin bad++; $display("FAIL second_clk_out got=%b want=0", bus.clk_out); end
   endtask

   task automatic test_bounce;
      int n;
      bus.btn_speed = 1'b1; edges(2);
      bus.btn_speed = 1'b0; edges(1);
      bus.btn_speed = 1'b1; edges(2);
      bus.btn_speed = 1'b0; edges(5);
      total++;
      if (bus.speed !== 2'd0) begin bad++; $display("FAIL bounce_speed got=%0d want=0", bus.speed); end
      cycles_to_tick(n);
      total++;
      if (n != 6) begin bad++; $display("FAIL bounce_partial got=%0d want=6", n); end
      cycles_to_tick(n);
      total++;
      if (n != 16) begin bad++; $display("FAIL bounce_period got=%0d want=16", n); end
   endtask

   task automatic test_clean_press;
      int n;
      bus.btn_speed = 1'b1;
      edges(6);
      total++;
      if (bus.speed !== 2'd0) begin bad++; $display("FAIL press_early got=%0d want=0", bus.speed); end
      edges(1);
      total += 2;
      if (bus.speed !== 2'd1) begin bad++; $display("FAIL press_speed got=%0d want=1", bus.speed); end
      if (bus.tick !== 1'b0) begin bad++; $display("FAIL press_tick got=%b want=0", bus.tick); end
      edges(3);
      bus.btn_speed = 1'b0;
      cycles_to_tick(n);
      total++;
      if (n != 5) begin bad++; $display("FAIL press_restart got=%0d want=5", n); end
      cycles_to_tick(n);
      total++;
      if (n != 8) begin bad++; $display("FAIL press_period got=%0d want=8", n); end
   endtask

   task automatic test_wrap_hold;
      int n;
      speed_t exp_s[4] = '{2'd2, 2'd3, 2'd0, 2'd1};
      int exp_p[4] = '{4, 2, 16, 8};
      for (int i = 0; i < 4; i++) begin
         press_once(10);
         total++;
         if (bus.speed !== exp_s[i]) begin bad++; $display("FAIL wrap_speed[%0d] got=%0d want=%0d", i, bus.speed, exp_s[i]); end
         cycles_to_tick(n);
         cycles_to_tick(n);
         total++;
         if (n != exp_p[i]) begin bad++; $display("FAIL wrap_period[%0d] got=%0d want=%0d", i, n, exp_p[i]); end
      end
      press_once(50);
      total++;
      if (bus.speed !== 2'd2) begin bad++; $display("FAIL hold_speed got=%0d want=2", bus.speed); end
      cycles_to_tick(n);
      cycles_to_tick(n);
      total++;
      if (n != 4) begin bad++; $display("FAIL hold_period got=%0d want=4", n); end
   endtask

   task automatic test_collision;
      int n;
      logic c;
      edges(1);
      bus.btn_speed = 1'b1;
      edges(6);
      c = bus.clk_out;
      edges(1);
      total += 3;
      if (bus.tick !== 1'b0) begin bad++; $display("FAIL coll_tick got=%b want=0", bus.tick); end
      if (bus.clk_out !== c) begin bad++; $display("FAIL coll_clk_out got=%b want=%b", bus.clk_out, c); end
      if (bus.speed !== 2'd3) begin bad++; $display("FAIL coll_speed got=%0d want=3", bus.speed); end
      cycles_to_tick(n);
      total++;
      if (n != 2) begin bad++; $display("FAIL coll_next got=%0d want=2", n); end
      bus.btn_speed = 1'b0;
      edges(10);
   endtask

   task automatic test_async_reset;
      int n;
      bus.btn_speed = 1'b1;
      edges(4);
      #1 reset = 1'b0;
      #1;
      total += 3;
      if (bus.speed !== 2'd0) begin bad++; $display("FAIL async_speed got=%0d want=0", bus.speed); end
      if (bus.tick !== 1'b0) begin bad++; $display("FAIL async_tick got=%b want=0", bus.tick); end
      if (bus.clk_out !== 1'b0) begin bad++; $display("FAIL async_clk_out got=%b want=0", bus.clk_out); end
      bus.btn_speed = 1'b0;
      edges(3);
      reset = 1'b1;
      cycles_to_tick(n);
      total += 2;
      if (n != 16) begin bad++; $display("FAIL async_first_tick got=%0d want=16", n); end
      if (bus.speed !== 2'd0) begin bad++; $display("FAIL async_discard got=%0d want=0", bus.speed); end
   endtask

`ifdef LED_TICK_PAUSE_EN
   task automatic test_pause;
      int n;
      int seen;
      seen = 0;
      edges(5);
      bus.pause = 1'b1;
      for (int i = 0; i < 20; i++) begin
         edges(1);
         if (bus.tick) seen++;
      end
      total++;
      if (seen != 0) begin bad++; $display("FAIL pause_ticks got=%0d want=0", seen); end
      bus.pause = 1'b0;
      cycles_to_tick(n);
      total++;
      if (n != 11) begin bad++; $display("FAIL pause_resume got=%0d want=11", n); end
   endtask
`endif

   initial begin
      test_reset();
      test_bounce();
      test_clean_press();
      test_wrap_hold();
      test_collision();
      test_async_reset();
`ifdef LED_TICK_PAUSE_EN
      test_pause();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
